// File: rtl/csr_bank.sv
// CSR-addressable register table with prioritised external write ports.
// Optional sequential clear walker is compiled in when CSR_BANK_CLEAR_EN is defined.
package csr_bank_pkg;
   typedef logic [11:0] csr_addr_t;
   typedef enum logic [2:0] {
      CSR_RW  = 3'b001,
      CSR_RS  = 3'b010,
      CSR_RC  = 3'b011,
      CSR_RWI = 3'b101,
      CSR_RSI = 3'b110,
      CSR_RCI = 3'b111
   } csr_op_t;
endpackage

module csr_bank
   import csr_bank_pkg::*;
#(
   parameter int unsigned          DataWidth    = 32,
   parameter int unsigned          TableSize    = 16,
   parameter csr_addr_t            BottomRange  = 12'h000,
   parameter int unsigned          NumExtPorts  = 2,
   parameter logic [DataWidth-1:0] WritableMask = '1,
   parameter logic [DataWidth-1:0] ResetValue   = '0,
   localparam int unsigned         IdxBits      = $clog2(TableSize)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 csr_enable,
   input  csr_addr_t            csr_addr,
   input  csr_op_t              csr_op,
   input  logic [4:0]           rs1_zimm,
   input  logic [31:0]          rs1_data,
   output logic                 csr_hit,
   output logic [DataWidth-1:0] csr_rdata,
   input  logic [DataWidth-1:0] ext_data [NumExtPorts],
   input  logic                 ext_we   [NumExtPorts],
   input  logic [IdxBits-1:0]   ext_idx  [NumExtPorts],
   output logic                 ext_ack  [NumExtPorts],
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic                 clear_done,
   output logic [DataWidth-1:0] out_table        [TableSize],
   output logic [DataWidth-1:0] direct_out_table [TableSize]
);

   // Non-writable bits always read back as their reset value.
   function automatic logic [DataWidth-1:0] apply_mask(input logic [DataWidth-1:0] v);
      return (v & WritableMask) | (ResetValue & ~WritableMask);
   endfunction

   logic [31:0]          addr_off;
   logic [IdxBits-1:0]   csr_idx;
   logic [DataWidth-1:0] csr_operand;
   logic [DataWidth-1:0] csr_old;
   logic [DataWidth-1:0] csr_wdata;
   logic                 csr_wr_op;
   logic                 csr_we;
   logic                 clear_active;
   logic [IdxBits-1:0]   clear_cnt;

   always_comb begin
      addr_off    = 32'(csr_addr) - 32'(BottomRange);
      csr_idx     = addr_off[IdxBits-1:0];
      csr_hit     = reset && csr_enable && (32'(csr_addr) >= 32'(BottomRange)) &&
                    (addr_off < TableSize);
      csr_old     = out_table[csr_idx];
      csr_rdata   = csr_hit ? csr_old : '0;
      csr_operand = csr_op[2] ? DataWidth'(rs1_zimm) : DataWidth'(rs1_data);
      case (csr_op)
         CSR_RW, CSR_RWI: begin
            csr_wdata = csr_operand;
            csr_wr_op = 1'b1;
         end
         CSR_RS, CSR_RSI: begin
            csr_wdata = csr_old | csr_operand;
            csr_wr_op = |csr_operand;
         end
         CSR_RC, CSR_RCI: begin
            csr_wdata = csr_old & ~csr_operand;
            csr_wr_op = |csr_operand;
         end
         default: begin
            csr_wdata = csr_old;
            csr_wr_op = 1'b0;
         end
      endcase
      csr_we = csr_hit && csr_wr_op;
   end

`ifdef CSR_BANK_CLEAR_EN
   typedef enum logic {IDLE, CLEAR} clear_state_t;
   clear_state_t clear_state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         clear_state <= IDLE;
         clear_cnt   <= '0;
         clear_busy  <= 1'b0;
         clear_done  <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (clear_state)
            IDLE: begin
               if (clear_req) begin
                  clear_state <= CLEAR;
                  clear_cnt   <= '0;
                  clear_busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (32'(clear_cnt) == TableSize - 1) begin
                  clear_state <= IDLE;
                  clear_cnt   <= '0;
                  clear_busy  <= 1'b0;
                  clear_done  <= 1'b1;
               end else begin
                  clear_cnt <= clear_cnt + IdxBits'(1);
               end
            end
            default: clear_state <= IDLE;
         endcase
      end
   end

   assign clear_active = (clear_state == CLEAR);
`else
   logic unused_clear_req;
   assign unused_clear_req = clear_req;
   assign clear_active     = 1'b0;
   assign clear_cnt        = '0;
   assign clear_busy       = 1'b0;
   assign clear_done       = 1'b0;
`endif

   // Per-entry arbitration: clear walker, then CSR, then ext ports in index order.
   always_comb begin
      logic taken;
      taken = 1'b0;
      for (int unsigned p = 0; p < NumExtPorts; p++) ext_ack[p] = 1'b0;
      for (int unsigned e = 0; e < TableSize; e++) begin
         taken               = 1'b0;
         direct_out_table[e] = out_table[e];
         if (clear_active && (32'(clear_cnt) == e)) begin
            direct_out_table[e] = ResetValue;
            taken               = 1'b1;
         end else if (csr_we && (32'(csr_idx) == e)) begin
            direct_out_table[e] = apply_mask(csr_wdata);
            taken               = 1'b1;
         end
         for (int unsigned p = 0; p < NumExtPorts; p++) begin
            if (!taken && ext_we[p] && (32'(ext_idx[p]) < TableSize) &&
                (32'(ext_idx[p]) == e)) begin
               direct_out_table[e] = apply_mask(ext_data[p]);
               ext_ack[p]          = 1'b1;
               taken               = 1'b1;
            end
         end
      end
      if (!reset) begin
         for (int unsigned p = 0; p < NumExtPorts; p++) ext_ack[p] = 1'b0;
         for (int unsigned e = 0; e < TableSize; e++) direct_out_table[e] = ResetValue;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned e = 0; e < TableSize; e++) begin
         if (!reset) out_table[e] <= ResetValue;
         else        out_table[e] <= direct_out_table[e];
      end
   end

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: vector table on a 16-entry bank plus a small masked bank.
// Clear-walker sequences are exercised when CSR_BANK_CLEAR_EN is defined.
module tb_csr_bank;
   import csr_bank_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Bank A: 16 entries at 0x340, two ext ports, full mask
   logic        a_en;
   csr_addr_t   a_addr;
   csr_op_t     a_op;
   logic [4:0]  a_zimm;
   logic [31:0] a_data;
   logic        a_hit;
   logic [31:0] a_rdata;
   logic [31:0] a_ext_data [2];
   logic        a_ext_we   [2];
   logic [3:0]  a_ext_idx  [2];
   logic        a_ext_ack  [2];
   logic        clear_req, clear_busy, clear_done;
   logic [31:0] a_tbl [16];
   logic [31:0] a_dir [16];

   // Bank B: 6 entries at 0x340, one ext port, low-byte mask
   logic        b_en;
   csr_addr_t   b_addr;
   csr_op_t     b_op;
   logic [4:0]  b_zimm;
   logic [31:0] b_data;
   logic        b_hit;
   logic [31:0] b_rdata;
   logic [31:0] b_ext_data [1];
   logic        b_ext_we   [1];
   logic [2:0]  b_ext_idx  [1];
   logic        b_ext_ack  [1];
   logic        b_clear_req, b_busy, b_done;
   logic [31:0] b_tbl [6];
   logic [31:0] b_dir [6];

   csr_bank #(.DataWidth(32), .TableSize(16), .BottomRange(12'h340), .NumExtPorts(2),
              .WritableMask(32'hFFFF_FFFF), .ResetValue(32'h0)) dut_a (
      .clk(clk), .reset(reset), .csr_enable(a_en), .csr_addr(a_addr), .csr_op(a_op),
      .rs1_zimm(a_zimm), .rs1_data(a_data), .csr_hit(a_hit), .csr_rdata(a_rdata),
      .ext_data(a_ext_data), .ext_we(a_ext_we), .ext_idx(a_ext_idx), .ext_ack(a_ext_ack),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .out_table(a_tbl), .direct_out_table(a_dir));

   csr_bank #(.DataWidth(32), .TableSize(6), .BottomRange(12'h340), .NumExtPorts(1),
              .WritableMask(32'h0000_00FF), .ResetValue(32'h0)) dut_b (
      .clk(clk), .reset(reset), .csr_enable(b_en), .csr_addr(b_addr), .csr_op(b_op),
      .rs1_zimm(b_zimm), .rs1_data(b_data), .csr_hit(b_hit), .csr_rdata(b_rdata),
      .ext_data(b_ext_data), .ext_we(b_ext_we), .ext_idx(b_ext_idx), .ext_ack(b_ext_ack),
      .clear_req(b_clear_req), .clear_busy(b_busy), .clear_done(b_done),
      .out_table(b_tbl), .direct_out_table(b_dir));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        en;
      logic [11:0] addr;
      csr_op_t     op;
      logic [31:0] opnd;
      logic [1:0]  we;
      logic [3:0]  idx0;
      logic [31:0] d0;
      logic [3:0]  idx1;
      logic [31:0] d1;
      logic        hit;
      logic [31:0] rdata;
      logic [1:0]  ack;
      int          chk;
      logic [31:0] val;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic [11:0] addr, input csr_op_t op,
                               input logic [31:0] opnd, input logic [1:0] we,
                               input logic [3:0] idx0, input logic [31:0] d0,
                               input logic [3:0] idx1, input logic [31:0] d1,
                               input logic hit, input logic [31:0] rdata,
                               input logic [1:0] ack, input int chk, input logic [31:0] val);
      vec_t v;
      v.en = en; v.addr = addr; v.op = op; v.opnd = opnd; v.we = we;
      v.idx0 = idx0; v.d0 = d0; v.idx1 = idx1; v.d1 = d1;
      v.hit = hit; v.rdata = rdata; v.ack = ack; v.chk = chk; v.val = val;
      return v;
   endfunction

   task automatic idle_a();
      a_en = 1'b0; a_addr = 12'h0; a_op = CSR_RW; a_zimm = 5'd0; a_data = 32'h0;
      for (int p = 0; p < 2; p++) begin
         a_ext_we[p] = 1'b0; a_ext_idx[p] = 4'd0; a_ext_data[p] = 32'h0;
      end
   endtask

   task automatic idle_b();
      b_en = 1'b0; b_addr = 12'h0; b_op = CSR_RW; b_zimm = 5'd0; b_data = 32'h0;
      b_ext_we[0] = 1'b0; b_ext_idx[0] = 3'd0; b_ext_data[0] = 32'h0;
   endtask

   vec_t vecs [18];

   initial begin
      vecs[0]  = mk(1'b1, 12'h342, CSR_RW,  32'hDEAD_BEEF, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0,         2'b00, 2,  32'hDEAD_BEEF);
      vecs[1]  = mk(1'b1, 12'h342, CSR_RS,  32'h0,         2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'hDEAD_BEEF, 2'b00, 2,  32'hDEAD_BEEF);
      vecs[2]  = mk(1'b1, 12'h341, CSR_RW,  32'h0000_00F0, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0,         2'b00, 1,  32'h0000_00F0);
      vecs[3]  = mk(1'b1, 12'h341, CSR_RS,  32'h0000_000F, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0000_00F0, 2'b00, 1,  32'h0000_00FF);
      vecs[4]  = mk(1'b1, 12'h341, CSR_RCI, 32'h0000_0F00, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0000_00FF, 2'b00, 1,  32'h0000_00FF);
      vecs[5]  = mk(1'b1, 12'h341, CSR_RCI, 32'h0000_FF03, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0000_00FF, 2'b00, 1,  32'h0000_00FC);
      vecs[6]  = mk(1'b1, 12'h341, CSR_RSI, 32'hFFFF_FFE1, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0000_00FC, 2'b00, 1,  32'h0000_00FD);
      vecs[7]  = mk(1'b1, 12'h342, CSR_RC,  32'hFFFF_0000, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'hDEAD_BEEF, 2'b00, 2,  32'h0000_BEEF);
      vecs[8]  = mk(1'b1, 12'h343, CSR_RWI, 32'h0000_001F, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0,         2'b00, 3,  32'h0000_001F);
      vecs[9]  = mk(1'b1, 12'h343, CSR_RW,  32'h0000_1234, 2'b01, 4'd3, 32'h5555, 4'd0, 32'h0,    1'b1, 32'h0000_001F, 2'b00, 3,  32'h0000_1234);
      vecs[10] = mk(1'b0, 12'h343, CSR_RW,  32'h0,         2'b11, 4'd5, 32'hAAAA, 4'd5, 32'hBBBB, 1'b0, 32'h0,         2'b01, 5,  32'h0000_AAAA);
      vecs[11] = mk(1'b1, 12'h348, CSR_RW,  32'h0000_0088, 2'b11, 4'd6, 32'h66,   4'd7, 32'h77,   1'b1, 32'h0,         2'b11, 6,  32'h0000_0066);
      vecs[12] = mk(1'b1, 12'h347, CSR_RS,  32'h0,         2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0000_0077, 2'b00, 8,  32'h0000_0088);
      vecs[13] = mk(1'b1, 12'h350, CSR_RW,  32'h0000_0001, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b0, 32'h0,         2'b00, 0,  32'h0);
      vecs[14] = mk(1'b1, 12'h33F, CSR_RW,  32'h0000_0001, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b0, 32'h0,         2'b00, 15, 32'h0);
      vecs[15] = mk(1'b0, 12'h342, CSR_RW,  32'h0000_0005, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b0, 32'h0,         2'b00, 2,  32'h0000_BEEF);
      vecs[16] = mk(1'b1, 12'h34F, CSR_RW,  32'h0000_F00D, 2'b00, 4'd0, 32'h0,    4'd0, 32'h0,    1'b1, 32'h0,         2'b00, 15, 32'h0000_F00D);
      vecs[17] = mk(1'b0, 12'h000, CSR_RW,  32'h0,         2'b10, 4'd0, 32'h0,    4'd9, 32'h99,   1'b0, 32'h0,         2'b10, 9,  32'h0000_0099);

      // Reset with live requests: nothing hits, acks or commits
      reset = 1'b0; clear_req = 1'b0; b_clear_req = 1'b0;
      idle_a(); idle_b();
      a_en = 1'b1; a_addr = 12'h342; a_op = CSR_RW; a_data = 32'h5;
      a_ext_we[0] = 1'b1; a_ext_idx[0] = 4'd1; a_ext_data[0] = 32'h77;
      @(negedge clk); #1;
      check("reset hit", 32'(a_hit), 32'h0);
      check("reset rdata", a_rdata, 32'h0);
      check("reset ack0", 32'(a_ext_ack[0]), 32'h0);
      @(negedge clk);
      check("reset tbl2", a_tbl[2], 32'h0);
      check("reset tbl1", a_tbl[1], 32'h0);
      reset = 1'b1; idle_a();
      @(negedge clk);
      for (int e = 0; e < 16; e++) check($sformatf("post-reset tbl%0d", e), a_tbl[e], 32'h0);
      check("post-reset busy", 32'(clear_busy), 32'h0);
      check("post-reset done", 32'(clear_done), 32'h0);

      // Vector table on bank A
      for (int i = 0; i < 18; i++) begin
         a_en = vecs[i].en; a_addr = vecs[i].addr; a_op = vecs[i].op;
         a_data = vecs[i].opnd; a_zimm = vecs[i].opnd[4:0];
         a_ext_we[0] = vecs[i].we[0]; a_ext_idx[0] = vecs[i].idx0; a_ext_data[0] = vecs[i].d0;
         a_ext_we[1] = vecs[i].we[1]; a_ext_idx[1] = vecs[i].idx1; a_ext_data[1] = vecs[i].d1;
         #1;
         check($sformatf("v%0d hit", i), 32'(a_hit), 32'(vecs[i].hit));
         check($sformatf("v%0d rdata", i), a_rdata, vecs[i].rdata);
         check($sformatf("v%0d ack", i), 32'({a_ext_ack[1], a_ext_ack[0]}), 32'(vecs[i].ack));
         check($sformatf("v%0d direct", i), a_dir[vecs[i].chk], vecs[i].val);
         @(posedge clk); #1;
         check($sformatf("v%0d table", i), a_tbl[vecs[i].chk], vecs[i].val);
         @(negedge clk);
      end
      idle_a();

      // Bank B: masked write, out-of-range ext index, masked ext write
      b_en = 1'b1; b_addr = 12'h341; b_op = CSR_RW; b_data = 32'h0000_FFFF;
      @(negedge clk);
      check("B masked RW", b_tbl[1], 32'h0000_00FF);
      idle_b();
      b_ext_we[0] = 1'b1; b_ext_idx[0] = 3'd6; b_ext_data[0] = 32'h12;
      #1 check("B idx=size ack", 32'(b_ext_ack[0]), 32'h0);
      @(negedge clk);
      b_ext_idx[0] = 3'd7;
      #1 check("B idx=7 ack", 32'(b_ext_ack[0]), 32'h0);
      @(negedge clk);
      for (int e = 0; e < 6; e++)
         check($sformatf("B oob tbl%0d", e), b_tbl[e], (e == 1) ? 32'h0000_00FF : 32'h0);
      b_ext_idx[0] = 3'd5; b_ext_data[0] = 32'hFFFF_1234;
      #1 check("B idx5 ack", 32'(b_ext_ack[0]), 32'h1);
      check("B idx5 direct", b_dir[5], 32'h0000_0034);
      @(negedge clk);
      check("B idx5 table", b_tbl[5], 32'h0000_0034);
      check("B busy", 32'(b_busy), 32'h0);
      idle_b();

`ifdef CSR_BANK_CLEAR_EN
      begin
         int busy_cnt;
         int done_cnt;
         busy_cnt = 0; done_cnt = 0;
         clear_req = 1'b1;
         @(negedge clk);
         clear_req = 1'b0;
         for (int c = 0; c < 24; c++) begin
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            idle_a();
            clear_req = (c == 8);
            if (c == 0) begin
               a_ext_we[0] = 1'b1; a_ext_idx[0] = 4'd0; a_ext_data[0] = 32'h1111;
               #1 check("clr c0 ack0", 32'(a_ext_ack[0]), 32'h0);
            end
            if (c == 1) check("clr entry0 lost", a_tbl[0], 32'h0);
            if (c == 3) begin
               a_ext_we[0] = 1'b1; a_ext_idx[0] = 4'd15; a_ext_data[0] = 32'h0F15;
               #1 check("clr c3 ack0", 32'(a_ext_ack[0]), 32'h1);
            end
            if (c == 4) check("clr entry15 landed", a_tbl[15], 32'h0F15);
            if (c == 16) check("clr done at c16", 32'(clear_done), 32'h1);
            @(negedge clk);
         end
         idle_a(); clear_req = 1'b0;
         check("clr busy cycles", 32'(busy_cnt), 32'd16);
         check("clr done pulses", 32'(done_cnt), 32'd1);
         for (int e = 0; e < 16; e++) check($sformatf("clr tbl%0d", e), a_tbl[e], 32'h0);

         // Reset in the middle of a walk
         a_en = 1'b1; a_addr = 12'h34A; a_op = CSR_RW; a_data = 32'h0000_00A0;
         @(negedge clk);
         idle_a();
         check("pre-abort tbl10", a_tbl[10], 32'h0000_00A0);
         clear_req = 1'b1;
         @(negedge clk);
         clear_req = 1'b0;
         repeat (5) @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         check("abort busy", 32'(clear_busy), 32'h0);
         busy_cnt = 0; done_cnt = 0;
         for (int c = 0; c < 20; c++) begin
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            @(negedge clk);
         end
         check("abort busy after", 32'(busy_cnt), 32'd0);
         check("abort no done", 32'(done_cnt), 32'd0);
         for (int e = 0; e < 16; e++) check($sformatf("abort tbl%0d", e), a_tbl[e], 32'h0);
      end
`else
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      check("noclr busy", 32'(clear_busy), 32'h0);
      check("noclr done", 32'(clear_done), 32'h0);
      @(negedge clk);
      check("noclr tbl2", a_tbl[2], 32'h0000_BEEF);
      check("noclr tbl15", a_tbl[15], 32'h0000_F00D);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
